// File: rtl/datapath_arbiter_pkg.sv
// Shared constants for the datapath arbiter: widths, FSM states and
// arbitration mode codes.
package datapath_arbiter_pkg;

    localparam int INSTRUCTION_WIDTH = 16;
    localparam int RESULT_WIDTH      = 16;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/datapath_arbiter_rr_arbiter.sv
// Combinational grant selection: round-robin after a pointer, or fixed
// priority with channel 0 highest.
module rr_arbiter
    import datapath_arbiter_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int ARB_MODE = ARB_RR,
    localparam int GW      = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [GW-1:0]   ptr,
    output logic [GW-1:0]   grant,
    output logic            any_req
);

    logic found;
    int   idx;

    always_comb begin
        grant   = '0;
        any_req = |req;
        found   = 1'b0;
        idx     = 0;
        if (ARB_MODE == ARB_FIXED) begin
            for (int i = N_CH - 1; i >= 0; i--) begin
                if (req[i]) grant = GW'(i);
            end
        end else begin
            // Scan starting just after the last served channel, wrapping.
            for (int k = 1; k <= N_CH; k++) begin
                idx = (int'(ptr) + k) % N_CH;
                if (!found && req[idx]) begin
                    grant = GW'(idx);
                    found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/datapath_arbiter.sv
// Shares one evaluation datapath among N_CH channels: per-channel request
// buffers, grant FSM, result return and optional WAIT timeout.
module datapath_arbiter
    import datapath_arbiter_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int INSTR_W  = INSTRUCTION_WIDTH,
    parameter int RES_W    = RESULT_WIDTH,
    parameter int ARB_MODE = ARB_RR,
    parameter int TIMEOUT  = 0
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [INSTR_W*N_CH-1:0] instruction,
    input  logic [N_CH-1:0]         start,
    output logic [RES_W*N_CH-1:0]   result,
    output logic [N_CH-1:0]         finished,
    output logic [N_CH-1:0]         dropped,
    output logic [N_CH-1:0]         timed_out,
    output logic [INSTR_W-1:0]      instruction_dp,
    output logic                    start_dp,
    input  logic [RES_W-1:0]        result_dp,
    input  logic                    finished_dp
);

    localparam int GW = $clog2(N_CH);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [GW-1:0] PTR_RST = GW'(N_CH - 1);

    state_t             state;
    logic [N_CH-1:0]    pending;
    logic [INSTR_W-1:0] ibuf [N_CH];
    logic [GW-1:0]      grant;
    logic [GW-1:0]      ptr;
    logic [GW-1:0]      arb_grant;
    logic               arb_any;
    logic [TW-1:0]      tcnt;

    logic               done_hit;
    logic               timeout_hit;
    logic [N_CH-1:0]    done_vec;
    logic [N_CH-1:0]    free;
    logic [N_CH-1:0]    accept;

    rr_arbiter #(
        .N_CH    (N_CH),
        .ARB_MODE(ARB_MODE)
    ) u_arb (
        .req    (pending),
        .ptr    (ptr),
        .grant  (arb_grant),
        .any_req(arb_any)
    );

    always_comb begin
        done_hit    = (state == ST_WAIT) && finished_dp;
        timeout_hit = 1'b0;
        if (TIMEOUT > 0) begin
            timeout_hit = (state == ST_WAIT) && !finished_dp
                        && (int'(tcnt) == TIMEOUT - 1);
        end
        done_vec = '0;
        if (done_hit || timeout_hit) done_vec[grant] = 1'b1;
        // A channel completing this cycle may take a new request at once.
        free   = finished | done_vec;
        accept = start & free;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pending   <= '0;
            finished  <= '1;
            dropped   <= '0;
            timed_out <= '0;
            result    <= '0;
            for (int i = 0; i < N_CH; i++) ibuf[i] <= '0;
        end else begin
            dropped <= start & ~free;
            for (int i = 0; i < N_CH; i++) begin
                if (accept[i]) timed_out[i] <= 1'b0;
                if (done_vec[i]) begin
                    pending[i]  <= 1'b0;
                    finished[i] <= 1'b1;
                    if (done_hit) result[i*RES_W +: RES_W] <= result_dp;
                    if (timeout_hit) timed_out[i] <= 1'b1;
                end
                if (accept[i]) begin
                    ibuf[i]     <= instruction[i*INSTR_W +: INSTR_W];
                    pending[i]  <= 1'b1;
                    finished[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state          <= ST_IDLE;
            grant          <= '0;
            ptr            <= PTR_RST;
            start_dp       <= 1'b0;
            instruction_dp <= '0;
            tcnt           <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    tcnt <= '0;
                    if (arb_any) begin
                        grant          <= arb_grant;
                        start_dp       <= 1'b1;
                        instruction_dp <= ibuf[arb_grant];
                        state          <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    start_dp <= 1'b0;
                    ptr      <= grant;
                    tcnt     <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done_hit || timeout_hit) begin
                        state <= ST_IDLE;
                    end else if (TIMEOUT > 0 && int'(tcnt) < TIMEOUT) begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
